// File: rtl/cr_huf_comp_sim_sel.sv
// Selector behind the parallel simulated-size engines: waits for the engines to
// report, picks the smallest Huffman size, hands it downstream, then releases every engine.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

module cr_huf_comp_sim_sel #(
    parameter int NUM_ENG     = 2,
    parameter int SIZE_WIDTH  = 20,
    parameter int SEQID_WIDTH = `CREOLE_HC_SEQID_WIDTH,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_ENG-1:0]             eng_size_rdy,
    input  logic [NUM_ENG*SIZE_WIDTH-1:0]  eng_sim_size,
    input  logic [NUM_ENG*SEQID_WIDTH-1:0] eng_seq_id,
    input  logic [NUM_ENG*2-1:0]           eng_eob,
    output logic [NUM_ENG-1:0]             eng_read_done,
    output logic                           sel_vld,
    input  logic                           sel_rdy,
    output logic [1:0]                     sel_idx,
    output logic [SIZE_WIDTH-1:0]          sel_size,
    output logic [SEQID_WIDTH-1:0]         sel_seq_id,
    output logic [1:0]                     sel_eob,
    output logic [1:0]                     sel_err,
    output logic                           busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WAIT = 3'd1;
    localparam logic [2:0] CMP  = 3'd2;
    localparam logic [2:0] OUT  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [1:0] MIDDLE = 2'd0;

    logic [2:0]         state;
    logic [NUM_ENG-1:0] seen;
    logic [NUM_ENG-1:0] seen_nxt;
    logic               all_seen;
    logic [TMR_W-1:0]   timer;

    logic                   found;
    logic [1:0]             best_idx;
    logic [SIZE_WIDTH-1:0]  best_size;
    logic [SEQID_WIDTH-1:0] best_seq;
    logic [1:0]             best_eob;
    logic [SEQID_WIDTH-1:0] ref_seq;
    logic                   seq_mismatch;

    assign seen_nxt      = seen | eng_size_rdy;
    assign all_seen      = &seen_nxt;
    assign busy          = (state != IDLE);
    assign eng_read_done = {NUM_ENG{state == DONE}};

    // Minimum search restricted to seen engines; strict '<' keeps ties on the lowest index.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no latch is inferred.
        found        = 1'b0;
        best_idx     = '0;
        best_size    = '0;
        best_seq     = '0;
        best_eob     = MIDDLE;
        ref_seq      = '0;
        seq_mismatch = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (seen[i]) begin
                if (!found) begin
                    found     = 1'b1;
                    ref_seq   = eng_seq_id[i*SEQID_WIDTH +: SEQID_WIDTH];
                    best_idx  = 2'(i);
                    best_size = eng_sim_size[i*SIZE_WIDTH +: SIZE_WIDTH];
                    best_seq  = eng_seq_id[i*SEQID_WIDTH +: SEQID_WIDTH];
                    best_eob  = eng_eob[i*2 +: 2];
                end else begin
                    if (eng_seq_id[i*SEQID_WIDTH +: SEQID_WIDTH] != ref_seq)
                        seq_mismatch = 1'b1;
                    if (eng_sim_size[i*SIZE_WIDTH +: SIZE_WIDTH] < best_size) begin
                        best_idx  = 2'(i);
                        best_size = eng_sim_size[i*SIZE_WIDTH +: SIZE_WIDTH];
                        best_seq  = eng_seq_id[i*SEQID_WIDTH +: SEQID_WIDTH];
                        best_eob  = eng_eob[i*2 +: 2];
                    end
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            seen       <= '0;
            timer      <= '0;
            sel_vld    <= 1'b0;
            sel_idx    <= '0;
            sel_size   <= '0;
            sel_seq_id <= '0;
            sel_eob    <= MIDDLE;
            sel_err    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (|eng_size_rdy) begin
                        seen  <= eng_size_rdy;
                        state <= (&eng_size_rdy) ? CMP : WAIT;
                    end
                end
                WAIT: begin
                    seen  <= seen_nxt;
                    timer <= timer + 1'b1;
                    // Arrival of the last engine takes priority over the timeout.
                    if (all_seen) begin
                        state <= CMP;
                    end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        sel_err[1] <= 1'b1;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    sel_idx    <= best_idx;
                    sel_size   <= best_size;
                    sel_seq_id <= best_seq;
                    sel_eob    <= best_eob;
                    sel_err[0] <= seq_mismatch;
                    sel_vld    <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (sel_rdy) begin
                        sel_vld <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    seen    <= '0;
                    sel_err <= '0;
                    sel_vld <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cr_huf_comp_sim_sel.md
Name: cr_huf_comp_sim_sel

Overview:
- Scheduler/selector that sits behind NUM_ENG parallel simulated-size engines. Each engine simulates Huffman encoded size with a different candidate code table.
- Waits for every engine to report a finished block size, then picks the smallest size and presents that choice to the downstream table-build stage through a valid/ready handshake.
- After the handshake it pulses the per-engine read-done, which releases all engines for the next block.
- Also flags sequence-ID mismatch between engines and timeout of a missing engine.

Parameters:
- NUM_ENG, 2, number of sim engines arbitrated (2..4).
- SIZE_WIDTH, 20, width of each simulated size.
- SEQID_WIDTH, `CREOLE_HC_SEQID_WIDTH, sequence ID width.
- TIMEOUT_CYC, 64, cycles to wait for the remaining engines after the first ready.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Synchronous, active-high: asserted when 1.
- eng_size_rdy  in  NUM_ENG  per-engine level: size final. Held until that engine's read_done.
- eng_sim_size  in  NUM_ENG*SIZE_WIDTH  per-engine simulated size, bit-packed with engine i at [i*SIZE_WIDTH +: SIZE_WIDTH].
- eng_seq_id  in  NUM_ENG*SEQID_WIDTH  per-engine sequence ID, packed the same way.
- eng_eob  in  NUM_ENG*2  per-engine e_pipe_eob, packed the same way.
- eng_read_done  out  NUM_ENG  one-cycle release pulse to every engine.
- sel_vld  out  1  selection valid.
- sel_rdy  in  1  downstream accepts.
- sel_idx  out  2  index of the winning engine.
- sel_size  out  SIZE_WIDTH  winning size.
- sel_seq_id  out  SEQID_WIDTH  winning engine's sequence ID.
- sel_eob  out  2  winning engine's eob.
- sel_err  out  2  bit0 = sequence-ID mismatch, bit1 = timeout. Valid with sel_vld.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, sel_eob=MIDDLE, state=IDLE, seen mask=0, timer=0. Reset mid-operation abandons the block; no eng_read_done is issued.

States:
- IDLE:
  - If any eng_size_rdy is high, latch it into the seen mask.
  - If all NUM_ENG are ready, go to CMP; otherwise go to WAIT.
  - Clear the timer.
- WAIT:
  - Each cycle: seen |= eng_size_rdy; timer++.
  - All seen -> CMP.
  - Timer == TIMEOUT_CYC-1 with not all seen -> set err[1], go to CMP.
  - If both happen in the same cycle, all-seen wins and no timeout is flagged.
- CMP (1 cycle):
  - Among engines in the seen mask only, choose the minimum eng_sim_size, compared unsigned. Ties go to the lowest index.
  - Set err[0] if any seen engine's seq_id differs from the lowest-index seen engine's seq_id.
  - Register the selection outputs, then go to OUT.
- OUT:
  - sel_vld=1; all selection outputs held stable until sel_vld & sel_rdy.
  - On the handshake go to DONE; sel_vld drops the next cycle.
- DONE (1 cycle):
  - eng_read_done = all ones, whether or not an engine was seen.
  - Clear the seen mask, sel_err and sel_vld; go to IDLE.
  - Engines drop size_rdy the cycle after read_done, so IDLE never re-captures a stale ready.

Timing and rules:
- Latency: last rdy sampled in cycle t gives CMP at t+1 and sel_vld at t+2. If all engines are ready in IDLE at t, sel_vld also rises at t+2.
- sel_rdy is ignored outside OUT. sel_rdy may be tied high, giving exactly one OUT cycle.
- Engines deasserting rdy before read_done do not clear the seen mask.
- Timer width is clog2(TIMEOUT_CYC+1) and it cannot wrap.
- eng_read_done is never asserted in any state except DONE.

Test Plan:
- 2 engines, sizes 0x01200 / 0x00F00, both rdy same cycle t, same seq_id 5, sel_rdy=1:
  - sel_vld at t+2, sel_idx=1, sel_size=0x00F00, sel_seq_id=5, sel_err=0.
  - eng_read_done=2'b11 at t+3.
- Equal sizes 0x00800 on both engines -> sel_idx=0 (tie goes to the lowest index).
- Engine0 rdy at t, engine1 rdy at t+10 with the smaller size:
  - busy from t+1.
  - sel_vld at t+12, sel_idx=1.
- Engine1 never ready, engine0 rdy at t, size 0x100:
  - Timeout fires after 64 WAIT cycles; sel_err=2'b10, sel_idx=0.
  - read_done=2'b11 after the handshake.
- seq_ids 3 vs 4 -> sel_err[0]=1; selection still by minimum size.
- sel_rdy held low for 20 cycles in OUT:
  - sel_vld and all selection outputs stable, no read_done.
  - On sel_rdy=1, read_done one cycle later, then IDLE.
- Assert rst_n in WAIT and in OUT:
  - Next cycle all outputs 0, sel_eob=MIDDLE.
  - No read_done pulse.
